mult_sched_arbiter: RTL and testbench
=====================================

# mult_sched_arbiter

Shares one sequential radix-2 shift-add multiplier between `NUM_REQ` independent requesters. Accepts operand pairs over per-requester valid/ready handshakes, arbitrates, drives the multiplier's load pulse and operands, waits the multiplier's fixed latency, then returns the product with the requester id over a single valid/ready response channel. It sits between the client datapaths and the multiplier instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `WIDTH`, 32, operand and result width.
- `MUL_LATENCY`, 33, cycles from the first rising edge after `mul_load` to a valid `mul_result`.
- `ID_W`, `$clog2(NUM_REQ)`, requester id width (derived, not overridden).

Ports:
- `clk`, in, 1, single clock; all logic is rising-edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `req_valid`, in, NUM_REQ, operand pair presented.
- `req_ready`, out, NUM_REQ, one-hot grant/accept.
- `req_a`, in, NUM_REQ*WIDTH, multiplicands (requester i at slice i).
- `req_b`, in, NUM_REQ*WIDTH, multipliers.
- `req_signed`, in, NUM_REQ, 1 = two's-complement operation.
- `mul_load`, out, 1, one-cycle start pulse to the multiplier.
- `mul_a`, out, WIDTH, latched multiplicand.
- `mul_b`, out, WIDTH, latched multiplier.
- `mul_signed`, out, 1, signed-operation select.
- `mul_result`, in, WIDTH, multiplier product (low WIDTH bits).
- `rsp_valid`, out, 1, response held.
- `rsp_ready`, in, 1, consumer accepts.
- `rsp_id`, out, ID_W, originating requester.
- `rsp_result`, out, WIDTH, captured product.

## Operation
- FSM states: IDLE, LOAD, BUSY, DONE.
- IDLE: the arbiter selects one requester among `req_valid`; `req_ready[g]` is high combinationally. On an edge with `req_valid[g] && req_ready[g]`, latch `req_a[g]`, `req_b[g]`, `req_signed[g]`, and `g`, then go to LOAD. With no request, stay in IDLE.
- LOAD: `mul_load`=1 for exactly one cycle. Load the counter with `MUL_LATENCY`, then go to BUSY.
- BUSY: decrement the counter each cycle. On the edge where counter==1, capture `mul_result` into `rsp_result` and go to DONE.
- DONE: `rsp_valid`=1. `rsp_id` and `rsp_result` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `req_ready` is all-zero outside IDLE. Requests are never dropped; an unserved `req_valid` waits.
- `mul_a`, `mul_b`, and `mul_signed` hold their latched values from LOAD through DONE.
- Round-robin: the priority pointer moves to (g+1) mod NUM_REQ on each accept. The search starts at the pointer and proceeds upward, wrapping.
- Result is the low WIDTH bits of the product; overflow is silently truncated. Sign interpretation belongs to the multiplier.

## Timing
- Reset values: `req_ready`=0, `mul_load`=0, `mul_a`=0, `mul_b`=0, `mul_signed`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0. The state is IDLE and the pointer is 0.
- Accept at edge E0: `mul_load` is high from E0 to E1. `rsp_valid` rises at edge E0+MUL_LATENCY+1.
- Minimum spacing between accepts is MUL_LATENCY+3 cycles (rsp_ready held high).
- Simultaneous requests: exactly one grant per accept.
- `rsp_ready` is ignored outside DONE.
- `rst` asserted in any state forces the reset values immediately and abandons the in-flight operation. Nothing is flushed in the multiplier.

## Configuration
- `MULT_SCHED_FIXED_PRIO_EN` defined: fixed priority; the lowest asserted index always wins, and the pointer logic is removed.
- Not defined: round-robin as described above.

## Structure
- Package `mult_sched_pkg` contains:
  - the `state_t` enum (IDLE, LOAD, BUSY, DONE);
  - the counter-width function.
- Sub-module `rr_arbiter` (NUM_REQ): request vector and advance strobe in, one-hot grant out. The fixed-priority variant lives inside it under the macro.

## Test plan
- Unsigned single request: req0 with 7×6 → `rsp_id`=0 and `rsp_result`=42, with `rsp_valid` exactly MUL_LATENCY+1 cycles after accept.
- Signed request: req1 with 24×-24, `req_signed`=1 → `rsp_result`=32'hFFFFFDC0, `rsp_id`=1, `mul_signed`=1 during LOAD.
- Contention: all four valid from reset and re-asserted after each accept → grant order 0,1,2,3,0. Under the macro, grants are 0,0,0.
- Backpressure: `rsp_ready` low for 10 cycles in DONE → `rsp_valid` and `rsp_result` stable, `req_ready`=0, no `mul_load`. Release → IDLE the next cycle.
- Reset mid-BUSY: pulse `rst` for 2 cycles → all outputs at reset values asynchronously. A still-pending req2 is re-accepted after release.
- Truncation: 0x00010000×0x00010000 unsigned → `rsp_result`=0.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        DONE
    } state_t;

    // Bits needed to hold a latency count from 0 up to and including latency.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter for the multiplier scheduler: one-hot grant from a request vector.
// Round-robin by default; MULT_SCHED_FIXED_PRIO_EN selects lowest-index-wins priority.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

`ifdef MULT_SCHED_FIXED_PRIO_EN

    // Lowest asserted index wins; no history is kept.
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
    end

    logic unused_rr;
    assign unused_rr = ^{clk, rst, advance};

`else

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] idx;
    logic            found;

    // Search upward from the pointer, wrapping, and grant the first request found.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // On an accepted grant g the pointer moves to the slot after g.
    always_comb begin
        ptr_d = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (advance && grant[i]) begin
                ptr_d = ID_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/mult_sched_arbiter.sv
// Shares one sequential multiplier between NUM_REQ requesters: arbitrate, load, wait the
// fixed multiplier latency, then hold the product on a valid/ready response channel.
// Build option: MULT_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mult_sched_arbiter
    import mult_sched_pkg::*;
#(
    parameter int unsigned  NUM_REQ     = 4,
    parameter int unsigned  WIDTH       = 32,
    parameter int unsigned  MUL_LATENCY = 33,
    localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_signed,
    output logic                     mul_load,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_signed,
    input  logic [WIDTH-1:0]         mul_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result
);

    localparam int unsigned CNT_W = cnt_width(MUL_LATENCY);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               signed_q;
    logic [ID_W-1:0]    id_q;
    logic               mul_load_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_result_q;

    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_signed;
    logic [ID_W-1:0]    sel_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Grants are only offered while idle; reset masks them immediately.
    assign req_ready = ((state_q == IDLE) && !rst) ? grant : '0;
    assign accept    = (state_q == IDLE) && (grant != '0);

    // One-hot mux of the granted requester's operands and id.
    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        sel_signed = 1'b0;
        sel_id     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a      = req_a[i*WIDTH +: WIDTH];
                sel_b      = req_b[i*WIDTH +: WIDTH];
                sel_signed = req_signed[i];
                sel_id     = ID_W'(i);
            end
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            signed_q     <= 1'b0;
            id_q         <= '0;
            mul_load_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            mul_load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        signed_q   <= sel_signed;
                        id_q       <= sel_id;
                        mul_load_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q   <= CNT_W'(MUL_LATENCY);
                    state_q <= BUSY;
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // The product is valid on the edge where the count reaches one.
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_result_q <= mul_result;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_load   = mul_load_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_signed = signed_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_mult_sched_arbiter.sv
// Self-checking bench for mult_sched_arbiter: directed cases plus randomized traffic,
// a timing-level reference model, and a scoreboard for responses.
`timescale 1ns/1ps
module tb_mult_sched_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int L   = 33;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_signed;
    logic           mul_load;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_signed;
    logic [W-1:0]   mul_result = '0;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_result;

    mult_sched_arbiter #(
        .NUM_REQ     (N),
        .WIDTH       (W),
        .MUL_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .mul_load   (mul_load),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier stand-in: garbage until the product is due, valid L edges after load.
    int mcnt = 0;
    always @(posedge clk) begin
        if (mul_load) begin
            mcnt       <= L - 1;
            mul_result <= $urandom;
        end else if (mcnt > 0) begin
            mcnt       <= mcnt - 1;
            mul_result <= (mcnt == 1) ? mul_a * mul_b : $urandom;
        end
    end

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   res;
    } exp_t;
    exp_t sb[$];

    // Response monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d, required no response", rsp_id);
            end else begin
                check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                check("rsp_result", 64'(rsp_result), 64'(sb[0].res));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    // Stimulus and reference-model state.
    logic         pend [N];
    logic [W-1:0] pa   [N];
    logic [W-1:0] pb   [N];
    logic         ps   [N];
    bit           busy     = 0;
    int           ptr      = 0;
    int           acc_cyc  = 0;
    int           rise_cyc = 0;
    logic [W-1:0] ea, eb;
    logic         es;
    int           rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
    bit           auto_gen = 0;
    bit           regen    = 0;
    int           dut_grants[$];

    function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef MULT_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
`endif
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1;
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_a[i*W +: W]     = pa[i];
            req_b[i*W +: W]     = pb[i];
            req_signed[i]       = ps[i];
        end
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        ps[i]   = s;
    endtask

    task automatic new_req(input int i);
        set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    // One clock: check outputs against the model at the falling edge, update stimulus after.
    task automatic step();
        int           g;
        logic [N-1:0] v;
        logic [N-1:0] er;
        g = -1;
        @(negedge clk);
        for (int i = 0; i < N; i++) v[i] = pend[i];
        if (!busy) begin
            g  = pick(v, ptr);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(er));
            check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
            check("mul_load_idle", 64'(mul_load), 64'(0));
            for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
            if (g >= 0) begin
                busy     = 1;
                acc_cyc  = cyc + 1;
                rise_cyc = acc_cyc + L + 1;
                ea       = pa[g];
                eb       = pb[g];
                es       = ps[g];
                sb.push_back('{id: IDW'(g), res: pa[g] * pb[g]});
                ptr      = (g + 1) % N;
            end
        end else begin
            check("req_ready_busy", 64'(req_ready), 64'(0));
            check("mul_load", 64'(mul_load), 64'(cyc == acc_cyc));
            check("rsp_valid", 64'(rsp_valid), 64'(cyc >= rise_cyc));
            check("mul_a", 64'(mul_a), 64'(ea));
            check("mul_b", 64'(mul_b), 64'(eb));
            check("mul_signed", 64'(mul_signed), 64'(es));
            if (cyc >= rise_cyc && rsp_ready) busy = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (g >= 0) begin
            pend[g] = 1'b0;
            if (regen) new_req(g);
        end
        if (auto_gen) begin
            for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 7) == 0) new_req(i);
        end
        drive();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((busy || any_pend()) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (busy || any_pend()) begin
            errors++;
            $display("FAIL drain_timeout: got work outstanding after %0d cycles, required idle", n);
        end
        check("sb_drained", 64'(sb.size()), 64'(0));
    endtask

    // Assert reset between edges and confirm outputs clear before any clock edge.
    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_mul_load", 64'(mul_load), 64'(0));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        check("rst_mul_signed", 64'(mul_signed), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_result", 64'(rsp_result), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        busy = 0;
        ptr  = 0;
        sb.delete();
    endtask

    int exp_order[5];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pb[i]   = '0;
            ps[i]   = 1'b0;
        end
        drive();
        apply_reset();

        // Unsigned single request.
        set_req(0, 32'd7, 32'd6, 1'b0);
        drive();
        run_until_idle(100);

        // Signed request: 24 x -24.
        set_req(1, 32'd24, 32'hFFFF_FFE8, 1'b1);
        drive();
        run_until_idle(100);

        // Truncation of the upper product bits.
        set_req(2, 32'h0001_0000, 32'h0001_0000, 1'b0);
        drive();
        run_until_idle(100);

        // Contention from reset with all requesters continuously re-asserting.
        apply_reset();
        for (int i = 0; i < N; i++) new_req(i);
        regen = 1;
        drive();
        dut_grants.delete();
        for (int n = 0; n < 400 && dut_grants.size() < 5; n++) step();
        regen = 0;
`ifdef MULT_SCHED_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            check("grant_order", (dut_grants.size() > i) ? 64'(dut_grants[i]) : 64'hFF,
                  64'(exp_order[i]));
        end
        run_until_idle(1000);

        // Backpressure: response held for well over ten cycles with another request waiting.
        rdy_mode = 2;
        set_req(3, 32'd5, 32'd9, 1'b0);
        drive();
        for (int n = 0; n < 10 && !busy; n++) step();
        set_req(0, 32'd11, 32'd13, 1'b0);
        drive();
        for (int n = 0; n < 100 && !(busy && cyc >= rise_cyc + 10); n++) step();
        check("backpressure_reached", 64'(busy && cyc >= rise_cyc + 10), 64'(1));
        rdy_mode = 0;
        drive();
        run_until_idle(200);

        // Reset while busy; the waiting requester 2 must be served afterwards.
        set_req(1, 32'd100, 32'd3, 1'b0);
        set_req(2, 32'd3, 32'd4, 1'b0);
        drive();
        for (int n = 0; n < 10; n++) step();
        apply_reset();
        dut_grants.delete();
        run_until_idle(200);
        check("regrant_req2", (dut_grants.size() > 0) ? 64'(dut_grants[0]) : 64'hFF, 64'(2));

        // Randomized traffic with random backpressure.
        auto_gen = 1;
        rdy_mode = 1;
        repeat (1500) step();
        auto_gen = 0;
        rdy_mode = 0;
        drive();
        run_until_idle(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
